// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared types and default timing for the push-button conditioning stage
package btn_pkg;

   typedef enum logic [1:0] {
      UP        = 2'd0,
      WAIT_DOWN = 2'd1,
      DOWN      = 2'd2,
      WAIT_UP   = 2'd3
   } btn_state_t;

   localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
   localparam int REPEAT_DELAY_DEF    = 50_000_000;
   localparam int REPEAT_RATE_DEF     = 10_000_000;

   localparam int BTN_U = 0;
   localparam int BTN_L = 1;
   localparam int BTN_R = 2;
   localparam int BTN_D = 3;

   function automatic logic is_down_level(input btn_state_t s);
      return (s == DOWN) || (s == WAIT_UP);
   endfunction

endpackage

// File: rtl/btn_channel.sv
// rtl/btn_channel.sv - one button: 2-flop synchroniser, debounce FSM, optional auto-repeat
// Auto-repeat hardware exists only when BTN_AUTOREPEAT_EN is defined.
module btn_channel
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
   parameter int REPEAT_RATE     = REPEAT_RATE_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic level,
   output logic press_pulse,
   output logic press_set
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   btn_state_t    state;
   btn_state_t    state_next;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_next;
   logic          press_event;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1       <= 1'b0;
         sync2       <= 1'b0;
         state       <= UP;
         cnt         <= '0;
         level       <= 1'b0;
         press_pulse <= 1'b0;
      end else begin
         sync1       <= btn_raw;
         sync2       <= sync1;
         state       <= state_next;
         cnt         <= cnt_next;
         level       <= is_down_level(state_next);
         press_pulse <= press_set;
      end
   end

   // Compare is >= so a corrupted count can never run past the terminal value.
   always_comb begin
      state_next  = state;
      cnt_next    = cnt;
      press_event = 1'b0;
      case (state)
         UP: begin
            if (sync2) begin
               state_next = WAIT_DOWN;
               cnt_next   = CNT_ONE;
            end
         end
         WAIT_DOWN: begin
            if (!sync2) begin
               state_next = UP;
               cnt_next   = '0;
            end else if (cnt >= CNT_LAST) begin
               state_next  = DOWN;
               cnt_next    = '0;
               press_event = 1'b1;
            end else begin
               cnt_next = cnt + CNT_ONE;
            end
         end
         DOWN: begin
            if (!sync2) begin
               state_next = WAIT_UP;
               cnt_next   = CNT_ONE;
            end
         end
         WAIT_UP: begin
            if (sync2) begin
               state_next = DOWN;
               cnt_next   = '0;
            end else if (cnt >= CNT_LAST) begin
               state_next = UP;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + CNT_ONE;
            end
         end
         default: begin
            state_next = UP;
            cnt_next   = '0;
         end
      endcase
   end

`ifdef BTN_AUTOREPEAT_EN
   localparam int RW = $clog2(REPEAT_DELAY + 1);
   localparam logic [RW-1:0] RPT_ONE    = RW'(1);
   localparam logic [RW-1:0] RPT_LAST   = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RPT_RELOAD = RW'(REPEAT_DELAY - REPEAT_RATE);

   logic [RW-1:0] rpt;
   logic [RW-1:0] rpt_next;
   logic          rpt_fire;

   // After the first repeat the counter reloads so later repeats come every REPEAT_RATE.
   always_comb begin
      rpt_next = '0;
      rpt_fire = 1'b0;
      if ((state == DOWN) && sync2) begin
         if (rpt >= RPT_LAST) begin
            rpt_fire = 1'b1;
            rpt_next = RPT_RELOAD;
         end else begin
            rpt_next = rpt + RPT_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rpt <= '0;
      end else begin
         rpt <= rpt_next;
      end
   end

   assign press_set = press_event | rpt_fire;
`else
   assign press_set = press_event;
`endif

endmodule

// File: rtl/btn_input.sv
// rtl/btn_input.sv - button conditioning top: per-channel debounce, sticky press flags for mmio
// Optional auto-repeat is enabled by defining BTN_AUTOREPEAT_EN.
module btn_input
   import btn_pkg::*;
#(
   parameter int N_BTN           = 4,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
   parameter int REPEAT_RATE     = REPEAT_RATE_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_BTN-1:0] btn_raw,
   input  logic             clr,
   input  logic [N_BTN-1:0] clr_mask,
   output logic [N_BTN-1:0] level,
   output logic [N_BTN-1:0] press_pulse,
   output logic [N_BTN-1:0] pressed,
   output logic             any_pressed
);

   logic [N_BTN-1:0] press_set;

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      btn_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_RATE     (REPEAT_RATE)
      ) u_ch (
         .clk         (clk),
         .reset       (reset),
         .btn_raw     (btn_raw[i]),
         .level       (level[i]),
         .press_pulse (press_pulse[i]),
         .press_set   (press_set[i])
      );
   end

   // Set is OR'd in after the clear so a press coinciding with clr keeps the flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         pressed     <= '0;
         any_pressed <= 1'b0;
      end else begin
         pressed     <= (pressed & ~(clr_mask & {N_BTN{clr}})) | press_set;
         any_pressed <= |pressed;
      end
   end

endmodule

// File: tb/tb_btn_input.sv
// tb/tb_btn_input.sv - directed bench for btn_input with a run-length reference model
module tb_btn_input;
   import btn_pkg::*;

   localparam int DEB   = 8;
   localparam int RDLY  = 20;
   localparam int RRATE = 5;

   logic       clk = 1'b0;
   logic       reset;
   logic       clr;
   logic [3:0] btn_raw;
   logic [3:0] clr_mask;
   logic [3:0] level;
   logic [3:0] press_pulse;
   logic [3:0] pressed;
   logic       any_pressed;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   btn_input #(
      .N_BTN           (4),
      .DEBOUNCE_CYCLES (DEB),
      .REPEAT_DELAY    (RDLY),
      .REPEAT_RATE     (RRATE)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .btn_raw     (btn_raw),
      .clr         (clr),
      .clr_mask    (clr_mask),
      .level       (level),
      .press_pulse (press_pulse),
      .pressed     (pressed),
      .any_pressed (any_pressed)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: the level flips once the synchronised input has disagreed with it
   // for DEB consecutive edges; repeats count edges held steadily down.
   logic [3:0] m_s1, m_s2, m_lvl, m_pulse, m_pressed;
   logic       m_any;
   int         m_run[4];
   int         m_held[4];

   always @(posedge clk) begin
      if (reset) begin
         m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pulse = '0; m_pressed = '0; m_any = 1'b0;
         for (int i = 0; i < 4; i++) begin
            m_run[i]  = 0;
            m_held[i] = 0;
         end
      end else begin
         logic [3:0] set_v;
         set_v = '0;
         for (int i = 0; i < 4; i++) begin
            int prev_run;
            bit prev_lvl;
            prev_run = m_run[i];
            prev_lvl = m_lvl[i];
            if (m_s2[i] != m_lvl[i]) begin
               m_run[i]++;
               if (m_run[i] == DEB) begin
                  m_lvl[i] = ~m_lvl[i];
                  m_run[i] = 0;
                  if (m_lvl[i]) begin
                     set_v[i]  = 1'b1;
                     m_held[i] = 0;
                  end
               end
            end else begin
               m_run[i] = 0;
            end
            if (prev_lvl && !m_s2[i]) begin
               m_held[i] = 0;
            end else if (prev_lvl && m_s2[i] && prev_run == 0) begin
               m_held[i]++;
`ifdef BTN_AUTOREPEAT_EN
               if (m_held[i] == RDLY || (m_held[i] > RDLY && (m_held[i] - RDLY) % RRATE == 0))
                  set_v[i] = 1'b1;
`endif
            end
         end
         m_any     = |m_pressed;
         m_pressed = (m_pressed & ~(clr ? clr_mask : 4'b0000)) | set_v;
         m_pulse   = set_v;
         m_s2      = m_s1;
         m_s1      = btn_raw;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_level", level, m_lvl);
         check("model_press_pulse", press_pulse, m_pulse);
         check("model_pressed", pressed, m_pressed);
         check("model_any_pressed", any_pressed, m_any);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_level(input int ch, input logic val, input int limit, output int k);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (level[ch] !== val && k < limit);
      if (level[ch] !== val) k = limit + 1;
   endtask

   int k;
   int seg_len[9] = '{5, 3, 5, 3, 7, 3, 1, 1, 6};
   bit saw;
   int pulses[$];

   initial begin
      reset = 1'b1; btn_raw = '0; clr = 1'b0; clr_mask = '0;
      @(negedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("reset_outputs", {level, press_pulse, pressed, any_pressed}, 13'h0);

      // single press on btnU
      btn_raw[BTN_U] = 1'b1;
      wait_level(BTN_U, 1'b1, 20, k);
      check("press_latency", k, 10);
      check("press_pulse_u", press_pulse, 4'b0001);
      check("pressed_u", pressed, 4'b0001);
      @(negedge clk);
      check("pulse_one_cycle", press_pulse, 4'b0000);
      check("any_pressed_follows", any_pressed, 1'b1);
      btn_raw[BTN_U] = 1'b0;
      wait_level(BTN_U, 1'b0, 20, k);
      check("release_latency", k, 10);

      // bounces shorter than the debounce window on btnL
      saw = 1'b0;
      for (int s = 0; s < 9; s++) begin
         btn_raw[BTN_L] = (s % 2 == 0);
         repeat (seg_len[s]) begin
            @(negedge clk);
            if (level[BTN_L] || press_pulse[BTN_L]) saw = 1'b1;
         end
      end
      btn_raw[BTN_L] = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (level[BTN_L] || press_pulse[BTN_L]) saw = 1'b1;
      end
      check("glitch_no_change", saw, 1'b0);
      check("glitch_no_pressed", pressed[BTN_L], 1'b0);

      // clear everything, then masked clear of btnR while held
      clr = 1'b1; clr_mask = 4'hf;
      @(negedge clk);
      clr = 1'b0; clr_mask = '0;
      check("clr_all", pressed, 4'b0000);
      @(negedge clk);
      check("clr_all_any", any_pressed, 1'b0);
      btn_raw[BTN_R] = 1'b1;
      wait_level(BTN_R, 1'b1, 20, k);
      check("press_latency_r", k, 10);
      tick(2);
      clr = 1'b1; clr_mask = 4'b0100;
      @(negedge clk);
      clr = 1'b0; clr_mask = '0;
      check("clr_pressed_r", pressed[BTN_R], 1'b0);
      check("clr_level_r_held", level[BTN_R], 1'b1);
      check("any_pressed_lags", any_pressed, 1'b1);
      @(negedge clk);
      check("any_pressed_cleared", any_pressed, 1'b0);
      btn_raw[BTN_R] = 1'b0;
      wait_level(BTN_R, 1'b0, 20, k);
      check("release_latency_r", k, 10);

      // clr on btnD in the same cycle its press is accepted: set wins
      btn_raw[BTN_D] = 1'b1;
      tick(9);
      clr = 1'b1; clr_mask = 4'b1000;
      @(negedge clk);
      clr = 1'b1; clr_mask = 4'b0001;
      check("set_wins_pulse", press_pulse, 4'b1000);
      check("set_wins_pressed", pressed, 4'b1000);
      @(negedge clk);
      clr = 1'b1; clr_mask = 4'b0000;
      check("clr_clear_bit_noop", pressed, 4'b1000);
      @(negedge clk);
      clr = 1'b0;
      check("clr_mask0_noop", pressed, 4'b1000);
      btn_raw[BTN_D] = 1'b0;
      wait_level(BTN_D, 1'b0, 20, k);
      check("release_latency_d", k, 10);

      // all four together
      btn_raw = 4'hf;
      k = 0;
      do begin @(negedge clk); k++; end while (press_pulse === 4'h0 && k < 20);
      check("all_press_latency", k, 10);
      check("all_press_pulse", press_pulse, 4'hf);
      check("all_level", level, 4'hf);
      btn_raw = 4'h0;
      saw = 1'b0;
      k = 0;
      do begin
         @(negedge clk);
         k++;
         if (press_pulse !== 4'h0) saw = 1'b1;
      end while (level !== 4'h0 && k < 20);
      check("all_release_latency", k, 10);
      check("release_no_pulse", saw, 1'b0);

      // reset while btnL sits mid-debounce, held through reset
      btn_raw[BTN_L] = 1'b1;
      tick(5);
      reset = 1'b1;
      @(negedge clk);
      check("reset_mid_debounce", {level, press_pulse, pressed, any_pressed}, 13'h0);
      reset = 1'b0;
      wait_level(BTN_L, 1'b1, 30, k);
      check("held_through_reset_latency", k, 10);
      btn_raw[BTN_L] = 1'b0;
      wait_level(BTN_L, 1'b0, 20, k);

`ifdef BTN_AUTOREPEAT_EN
      btn_raw[BTN_U] = 1'b1;
      wait_level(BTN_U, 1'b1, 20, k);
      check("rpt_entry_pulse", press_pulse[BTN_U], 1'b1);
      for (int off = 1; off <= 50; off++) begin
         @(negedge clk);
         if (press_pulse[BTN_U]) pulses.push_back(off);
         if (off == 31) btn_raw[BTN_U] = 1'b0;
      end
      check("rpt_count", pulses.size(), 3);
      check("rpt_first", (pulses.size() > 0) ? pulses[0] : -1, 20);
      check("rpt_second", (pulses.size() > 1) ? pulses[1] : -1, 25);
      check("rpt_third", (pulses.size() > 2) ? pulses[2] : -1, 30);
`endif

      tick(3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/btn_input.md
# btn_input

Button conditioning stage feeding the MMIO block. Takes the raw asynchronous push-button pins (btnU, btnL, btnR, btnD), synchronises and debounces each one, and presents stable levels, single-cycle press pulses and sticky press flags that the CPU reads and clears through MMIO. Sits between the top-level button pins and mmio; one instance per design.

## Interface
- N_BTN, 4, number of button channels; bit order {btnD, btnR, btnL, btnU} = [3:0]
- DEBOUNCE_CYCLES, 1_000_000, consecutive cycles a synchronised input must hold a new value before the stable level changes (10 ms at 100 MHz); legal range ≥ 2
- REPEAT_DELAY, 50_000_000, cycles held before the first auto-repeat pulse (used only with BTN_AUTOREPEAT_EN)
- REPEAT_RATE, 10_000_000, cycles between later auto-repeat pulses (used only with BTN_AUTOREPEAT_EN)

- clk  in  1  system clock, all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- btn_raw  in  N_BTN  raw button pins, asynchronous, active-high
- clr  in  1  one-cycle request from mmio to clear sticky flags
- clr_mask  in  N_BTN  which sticky flags clr clears (1 = clear)
- level  out  N_BTN  debounced button level
- press_pulse  out  N_BTN  one-cycle pulse per accepted press (and per repeat)
- pressed  out  N_BTN  sticky flag, set by press_pulse, cleared by clr
- any_pressed  out  1  OR-reduction of pressed, registered

## Operation
- Per channel: 2-flop synchroniser, then debounce counter, then 4-state FSM.
- FSM states: UP (level 0), WAIT_DOWN, DOWN (level 1), WAIT_UP.
  - UP: sync=1 -> WAIT_DOWN, counter=1.
  - WAIT_DOWN: sync=0 -> UP, counter cleared; sync=1 and counter = DEBOUNCE_CYCLES-1 -> DOWN; else counter+1.
  - DOWN: sync=0 -> WAIT_UP, counter=1.
  - WAIT_UP: sync=1 -> DOWN, counter cleared; sync=0 and counter = DEBOUNCE_CYCLES-1 -> UP; else counter+1.
- Counter width $clog2(DEBOUNCE_CYCLES); counter never wraps, saturating compare at DEBOUNCE_CYCLES-1.
- level = 1 in DOWN and WAIT_UP, 0 in UP and WAIT_DOWN.
- press_pulse fires on the WAIT_DOWN -> DOWN transition only; release produces no pulse.
- pressed[i] sets on press_pulse[i]; clears when clr && clr_mask[i]. Simultaneous set and clear on the same bit: set wins (flag stays 1).
- clr with clr_mask = 0 is a no-op; clr on an already-clear bit is a no-op.
- Channels are fully independent; simultaneous presses on several channels pulse in the same cycle.

## Timing
- Reset: all FSMs UP, counters 0, synchronisers 0; level, press_pulse, pressed, any_pressed all 0 in the cycle after reset is sampled high. Reset mid-debounce discards the partial count; a button held through reset needs a full DEBOUNCE_CYCLES after release of reset (plus 2 sync cycles) to register.
- Press latency: btn_raw rising to level/press_pulse/pressed rising = 2 + DEBOUNCE_CYCLES cycles, all three registered and coincident.
- Release latency: same, 2 + DEBOUNCE_CYCLES cycles to level falling.
- A glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no output change.
- clr takes effect on the next edge: pressed bit low the cycle after clr is sampled; any_pressed follows pressed with one further cycle latency.

## Configuration
- BTN_AUTOREPEAT_EN defined: in DOWN a per-channel repeat counter runs; first extra press_pulse REPEAT_DELAY cycles after entering DOWN, then one every REPEAT_RATE cycles while in DOWN; counter reset on leaving DOWN (WAIT_UP pauses nothing: any entry to WAIT_UP clears it). Repeat pulses set pressed like normal presses.
- Not defined: exactly one press_pulse per debounced press; repeat counter and REPEAT_* parameters have no hardware.

## Structure
- Package btn_pkg: state typedef enum {UP, WAIT_DOWN, DOWN, WAIT_UP}, default constants for DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE, and the button bit-index constants BTN_U=0, BTN_L=1, BTN_R=2, BTN_D=3.
- Sub-module btn_channel: synchroniser, debounce FSM, optional repeat counter for one button; btn_input generates N_BTN instances and owns the sticky flags and any_pressed.

## Test plan (DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_RATE=5)
- Reset, btn_raw=0 -> all outputs 0; btn_raw[0] held high -> level[0], press_pulse[0] (one cycle), pressed[0] rise exactly 10 cycles later.
- btn_raw[1] high for 5 cycles, low, repeated bounces -> no change on any output.
- Press btn 2 then clr=1, clr_mask=4'b0100 -> pressed[2] low next cycle, any_pressed low one cycle after; level[2] stays 1.
- clr with mask bit 3 in the same cycle as press_pulse[3] -> pressed[3] stays 1.
- All four buttons rise together -> press_pulse=4'b1111 in one cycle; release -> level falls 10 cycles later, no pulse.
- BTN_AUTOREPEAT_EN, hold btn 0 -> pulses at entry, +20, +25, +30 cycles; release mid-hold stops pulses; reset asserted while in WAIT_DOWN -> all outputs 0 next cycle.
